// File: rtl/clock_prescaler.sv
// Free-running 2^N clock prescaler: 50%-duty divided clock, a registered wrap strobe
// and the raw count for logic that stays in the system clock domain.
module clock_prescaler #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic         out,
  output logic         tick,
  output logic [N-1:0] count
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d  = cnt_q + N'(1);
      tick_d = &cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // The divided clock is taken straight from the counter MSB, so it is glitch-free.
  assign out   = cnt_q[N-1];
  assign tick  = tick_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_clock_prescaler.sv
// Scoreboard bench for clock_prescaler: N=4 and N=1 checked against an arithmetic
// model through an expectation queue; N=16 checked for period, duty and strobe rate.
module tb_clock_prescaler;

  logic clk = 1'b0;
  logic reset, en, clr, en16;
  logic out4, tick4, out1, tick1, out16, tick16;
  logic [3:0]  count4;
  logic [0:0]  count1;
  logic [15:0] count16;

  always #5 clk = ~clk;

  clock_prescaler #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .out(out4), .tick(tick4), .count(count4)
  );
  clock_prescaler #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .out(out1), .tick(tick1), .count(count1)
  );
  clock_prescaler dut16 (
    .clk(clk), .reset(reset), .en(en16), .clr(1'b0),
    .out(out16), .tick(tick16), .count(count16)
  );

  typedef struct {
    int unsigned c4;
    bit          t4;
    int unsigned c1;
    bit          t1;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m4 = 0;
  int unsigned m1 = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: next value from the priority rules, with plain modular arithmetic.
  task automatic step(input bit e, input bit c);
    exp_t x;
    @(negedge clk);
    en  = e;
    clr = c;
    x.c4 = c ? 0 : (e ? (m4 + 1) % 16 : m4);
    x.t4 = !c && e && (m4 == 15);
    x.c1 = c ? 0 : (e ? (m1 + 1) % 2 : m1);
    x.t1 = !c && e && (m1 == 1);
    m4 = x.c4;
    m1 = x.c1;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("count4", count4, x.c4);
        chk("out4",   out4,   (x.c4 >= 8) ? 1 : 0);
        chk("tick4",  tick4,  x.t4);
        chk("count1", count1, x.c1);
        chk("out1",   out1,   x.c1);
        chk("tick1",  tick1,  x.t1);
      end
    end
  end

  initial begin : driver
    int unsigned highs, ticks, first_high, guard;
    reset = 1'b1; en = 1'b0; clr = 1'b0; en16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count4", count4, 0);
    chk("rst_out4", out4, 0);
    chk("rst_tick4", tick4, 0);
    @(negedge clk);
    reset = 1'b0;

    // Free run: wrap strobes expected on edges 16 and 32.
    repeat (40) step(1'b1, 1'b0);
    // Enable gating at count 6.
    step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    // Clear priority at count 15.
    while (m4 != 15) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    // Enable dropped while tick is high.
    while (m4 != 15) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // Random mix of enable and clear.
    repeat (300) step(($urandom % 4) != 0, ($urandom % 16) == 0);

    // Asynchronous reset mid-cycle with count at 9.
    guard = 0;
    while (m4 != 9 && guard < 40) begin
      step(1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    chk("pre_rst_count4", count4, 9);
    #1 reset = 1'b1;
    #1;
    chk("async_count4", count4, 0);
    chk("async_out4", out4, 0);
    chk("async_tick4", tick4, 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_rst_count4", count4, 0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;
    m4 = 0;
    m1 = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Default width: one full 65536-cycle period.
    @(negedge clk);
    en = 1'b0;
    en16 = 1'b1;
    highs = 0; ticks = 0; first_high = 0;
    for (int unsigned k = 1; k <= 65536; k++) begin
      @(posedge clk);
      #1;
      if (out16) begin
        highs++;
        if (first_high == 0) first_high = k;
      end
      if (tick16) ticks++;
    end
    chk("n16_high_cycles", highs, 32768);
    chk("n16_first_rise", first_high, 32768);
    chk("n16_ticks", ticks, 1);
    chk("n16_wrap_count", count16, 0);
    chk("n16_wrap_tick", tick16, 1);
    @(negedge clk);
    en16 = 1'b0;

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
